// File: rtl/grah8_arb_pkg.sv
// Shared types and constants for the Grah-8 internal bus arbiter.
package grah8_arb_pkg;

   localparam int NUM_REQ = 4;
   localparam int ID_W    = 2;
   localparam int HOLD_W  = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      TURN  = 2'd2
   } arb_state_t;

   localparam logic [NUM_REQ-1:0] ONE_HOT_0 = NUM_REQ'(1);

   // Requester index to one-hot grant vector.
   function automatic logic [NUM_REQ-1:0] id_to_onehot(input logic [ID_W-1:0] id);
      return ONE_HOT_0 << id;
   endfunction

endpackage

// File: rtl/grah8_rr_pick.sv
// Combinational rotate-priority picker: first set request bit scanning
// upward from (last_id+1) with wrap-around.
module grah8_rr_pick
   import grah8_arb_pkg::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    last_id,
   output logic               any,
   output logic [ID_W-1:0]    winner
);

   // Scan the four positions after last_id; the 2-bit index wraps naturally.
   always_comb begin
      logic             found;
      logic [ID_W-1:0]  idx;
      found  = 1'b0;
      idx    = '0;
      winner = '0;
      any    = |req;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = last_id + ID_W'(k);
         if (!found && req[idx]) begin
            winner = idx;
            found  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/grah8_bus_arbiter.sv
// Round-robin arbiter for the Grah-8 shared 8-bit data bus. Issues one-hot
// registered grants with a bounded hold time and a one-cycle dead TURN slot
// between tenures so two bus drivers can never overlap.
//
// Handshake: req[i] is a level request; requester i may drive the bus in every
// cycle where gnt[i]=1. A tenure ends the cycle after req[grant_id] is seen
// low, or after MAX_HOLD granted cycles unless lock holds it open.
module grah8_bus_arbiter
   import grah8_arb_pkg::*;
#(
   parameter int    UUID     = 0,
   parameter string NAME     = "",
   parameter int    MAX_HOLD = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req,
   input  logic               lock,
   output logic [NUM_REQ-1:0] gnt,
   output logic [ID_W-1:0]    grant_id,
   output logic               busy,
   output arb_state_t         dbg_state_o
);

   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
   localparam logic [HOLD_W-1:0] HOLD_SAT  = '1;
   localparam logic [ID_W-1:0]   LAST_RST  = ID_W'(NUM_REQ - 1);

   arb_state_t           state_q;
   logic [ID_W-1:0]      last_id_q;
   logic [ID_W-1:0]      grant_id_q;
   logic [HOLD_W-1:0]    hold_q;
   logic [NUM_REQ-1:0]   gnt_q;
   logic                 busy_q;

   logic                 pick_any;
   logic [ID_W-1:0]      pick_winner;
   logic                 tenure_end_d;

   // One picker serves both IDLE and TURN; in TURN last_id_q already holds
   // the grantee that just finished, so it drops to lowest priority.
   grah8_rr_pick u_pick (
      .req     (req),
      .last_id (last_id_q),
      .any     (pick_any),
      .winner  (pick_winner)
   );

   // Tenure ends on request drop (even when locked) or on hold expiry.
   always_comb begin
      tenure_end_d = !req[grant_id_q] || ((hold_q == HOLD_LAST) && !lock);
   end

   // Arbiter FSM with registered grant, grant_id and busy.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         last_id_q  <= LAST_RST;
         grant_id_q <= '0;
         hold_q     <= '0;
         gnt_q      <= '0;
         busy_q     <= 1'b0;
      end else begin
         case (state_q)
            IDLE, TURN: begin
               if (pick_any) begin
                  state_q    <= GRANT;
                  grant_id_q <= pick_winner;
                  hold_q     <= '0;
                  gnt_q      <= id_to_onehot(pick_winner);
                  busy_q     <= 1'b1;
               end else begin
                  state_q <= IDLE;
                  gnt_q   <= '0;
                  busy_q  <= 1'b0;
               end
            end
            GRANT: begin
               if (tenure_end_d) begin
                  state_q   <= TURN;
                  last_id_q <= grant_id_q;
                  gnt_q     <= '0;
                  busy_q    <= 1'b0;
               end else if (!lock && (hold_q != HOLD_SAT)) begin
                  hold_q <= hold_q + HOLD_W'(1);
               end
            end
            default: begin
               state_q <= IDLE;
               gnt_q   <= '0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign gnt         = gnt_q;
   assign grant_id    = grant_id_q;
   assign busy        = busy_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_grah8_bus_arbiter.sv
// Directed bench for grah8_bus_arbiter. Five instances with different
// MAX_HOLD values share the clock and reset; each scenario drives one.
//   0: MAX_HOLD=8  1: MAX_HOLD=2  2: MAX_HOLD=4  3: MAX_HOLD=3  4: MAX_HOLD=1
module tb_grah8_bus_arbiter;
   import grah8_arb_pkg::*;

   localparam int N_DUT = 5;

   logic clk;
   logic rst;
   logic [3:0] req_a  [N_DUT];
   logic       lock_a [N_DUT];
   logic [3:0] gnt_a  [N_DUT];
   logic [1:0] gid_a  [N_DUT];
   logic       busy_a [N_DUT];
   arb_state_t st_a   [N_DUT];

   int checks   = 0;
   int failures = 0;

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   for (genvar g = 0; g < N_DUT; g++) begin : g_dut
      grah8_bus_arbiter #(
         .UUID     (g),
         .NAME     ("arb"),
         .MAX_HOLD ((g == 0) ? 8 : (g == 1) ? 2 : (g == 2) ? 4 : (g == 3) ? 3 : 1)
      ) u_dut (
         .clk         (clk),
         .rst         (rst),
         .req         (req_a[g]),
         .lock        (lock_a[g]),
         .gnt         (gnt_a[g]),
         .grant_id    (gid_a[g]),
         .busy        (busy_a[g]),
         .dbg_state_o (st_a[g])
      );
   end

   // driver helpers: inputs change and outputs are sampled 1 ns after posedge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   logic [3:0] rot_gnt [12] = '{4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h0,
                                4'h4, 4'h4, 4'h0, 4'h8, 4'h8, 4'h0};
   logic [1:0] rot_gid [12] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd0,
                                2'd2, 2'd2, 2'd0, 2'd3, 2'd3, 2'd0};
   logic [3:0] fair_gnt [12] = '{4'h1, 4'h1, 4'h1, 4'h0, 4'h2, 4'h2,
                                 4'h2, 4'h0, 4'h1, 4'h1, 4'h1, 4'h0};
   logic [3:0] mh1_gnt [6] = '{4'h1, 4'h0, 4'h2, 4'h0, 4'h1, 4'h0};

   initial begin
      logic [3:0] e;
      for (int k = 0; k < N_DUT; k++) begin
         req_a[k]  = 4'h0;
         lock_a[k] = 1'b0;
      end
      rst = 1'b1;
      #1 rst = 1'b0;
      tick();
      tick();

      // reset state
      for (int k = 0; k < N_DUT; k++) begin
         chk($sformatf("rst_gnt%0d", k), 32'(gnt_a[k]), 32'h0);
         chk($sformatf("rst_busy%0d", k), 32'(busy_a[k]), 32'h0);
         chk($sformatf("rst_gid%0d", k), 32'(gid_a[k]), 32'h0);
      end
      #2 rst = 1'b1;

      // single request, 3 cycles, then TURN, then IDLE
      tick(); tick(); tick();
      req_a[0] = 4'b0001;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("single_gnt_c%0d", i), 32'(gnt_a[0]), 32'h1);
         chk($sformatf("single_busy_c%0d", i), 32'(busy_a[0]), 32'h1);
         chk($sformatf("single_gid_c%0d", i), 32'(gid_a[0]), 32'h0);
      end
      req_a[0] = 4'b0000;
      tick();
      chk("single_turn_gnt", 32'(gnt_a[0]), 32'h0);
      chk("single_turn_busy", 32'(busy_a[0]), 32'h0);
      chk("single_turn_state", 32'(st_a[0]), 32'(TURN));
      tick();
      chk("single_idle_state", 32'(st_a[0]), 32'(IDLE));
      chk("single_idle_gnt", 32'(gnt_a[0]), 32'h0);

      // sole requester hitting hold expiry, MAX_HOLD=8
      req_a[0] = 4'b0100;
      for (int i = 0; i < 17; i++) begin
         tick();
         e = (i == 8) ? 4'h0 : 4'h4;
         chk($sformatf("hold_gnt_c%0d", i), 32'(gnt_a[0]), 32'(e));
         chk($sformatf("hold_busy_c%0d", i), 32'(busy_a[0]), 32'(e != 4'h0));
      end
      req_a[0] = 4'b0000;
      tick(); tick();

      // lock keeps tenure open, MAX_HOLD=4
      req_a[2]  = 4'b0010;
      lock_a[2] = 1'b1;
      for (int i = 0; i < 12; i++) begin
         tick();
         chk($sformatf("lock_gnt_c%0d", i), 32'(gnt_a[2]), 32'h2);
         chk($sformatf("lock_state_c%0d", i), 32'(st_a[2]), 32'(GRANT));
      end
      lock_a[2] = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("unlock_gnt_c%0d", i), 32'(gnt_a[2]), 32'h2);
      end
      tick();
      chk("unlock_expire_gnt", 32'(gnt_a[2]), 32'h0);
      tick();
      chk("unlock_regrant_gnt", 32'(gnt_a[2]), 32'h2);
      chk("unlock_regrant_gid", 32'(gid_a[2]), 32'h1);
      lock_a[2] = 1'b1;
      req_a[2]  = 4'b0000;
      tick();
      chk("lock_reqdrop_gnt", 32'(gnt_a[2]), 32'h0);
      lock_a[2] = 1'b0;
      tick();
      chk("lock_reqdrop_idle", 32'(st_a[2]), 32'(IDLE));

      // fairness under expiry, MAX_HOLD=3
      req_a[3] = 4'b0011;
      for (int i = 0; i < 12; i++) begin
         tick();
         chk($sformatf("fair_gnt_c%0d", i), 32'(gnt_a[3]), 32'(fair_gnt[i]));
      end
      req_a[3] = 4'b0000;
      tick(); tick();

      // MAX_HOLD=1: one-cycle tenures separated by TURN
      req_a[4] = 4'b0011;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk($sformatf("mh1_gnt_c%0d", i), 32'(gnt_a[4]), 32'(mh1_gnt[i]));
      end
      req_a[4] = 4'b0000;
      tick(); tick();

      // rotation with all requesting, MAX_HOLD=2, stop during gnt=1000
      req_a[1] = 4'b1111;
      for (int i = 0; i < 22; i++) begin
         tick();
         chk($sformatf("rot_gnt_c%0d", i), 32'(gnt_a[1]), 32'(rot_gnt[i % 12]));
         if (rot_gnt[i % 12] != 4'h0)
            chk($sformatf("rot_gid_c%0d", i), 32'(gid_a[1]), 32'(rot_gid[i % 12]));
      end

      // asynchronous reset between clock edges during gnt=1000
      #2 rst = 1'b0;
      #1;
      chk("arst_gnt", 32'(gnt_a[1]), 32'h0);
      chk("arst_busy", 32'(busy_a[1]), 32'h0);
      chk("arst_gid", 32'(gid_a[1]), 32'h0);
      chk("arst_state", 32'(st_a[1]), 32'(IDLE));
      #2 rst = 1'b1;
      tick();
      chk("arst_first_gnt", 32'(gnt_a[1]), 32'h1);
      chk("arst_first_gid", 32'(gid_a[1]), 32'h0);
      req_a[1] = 4'b0000;
      tick(); tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
